// File: rtl/octa16_pkg.sv
// Shared constants and types for the Octa16 register file.
package octa16_pkg;

  localparam int unsigned DefaultDataWidth = 16;
  localparam int unsigned DefaultAddrWidth = 3;
  localparam int unsigned ZeroRegIdx       = 0;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback or flush.
module reg_scoreboard
  import octa16_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter bit          ZERO_REG   = 1'b1,
  localparam int unsigned Depth     = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  output logic [Depth-1:0]      pending
);

  logic [Depth-1:0] pending_q, pending_d;
  logic             set_ok;

  assign set_ok = set_en && !(ZERO_REG && set_addr == ADDR_WIDTH'(ZeroRegIdx));

  // Set is applied after clear so a newer producer wins over a same-cycle writeback.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_ok) pending_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/reg_file_sb.sv
// Octa16 register file: 2 read / 1 write, write-to-read bypass, scoreboard, sequential clear.
module reg_file_sb
  import octa16_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rs1_en,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic                  rs1_busy,
  input  logic                  rs2_en,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs2_busy,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  clr_req,
  output logic                  clr_busy
);

  localparam int unsigned           Depth   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;
  localparam logic [ADDR_WIDTH-1:0] ZeroIdx = ADDR_WIDTH'(ZeroRegIdx);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [Depth-1:0]      pending;

  logic in_idle, in_clear, wr_ok;
  logic rs1_zero, rs2_zero, rs1_hit, rs2_hit;

  assign in_idle  = (state_q == StIdle);
  assign in_clear = (state_q == StClear);
  assign wr_ok    = in_idle && wr_en && !(ZERO_REG && wr_addr == ZeroIdx);
  assign clr_busy = in_clear;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (in_clear) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // During clear the engine owns the scoreboard clear port; issues are dropped.
  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (in_idle && issue_en),
    .set_addr (issue_rd),
    .clr_en   (in_clear || wr_en),
    .clr_addr (in_clear ? cnt_q : wr_addr),
    .pending  (pending)
  );

  assign rs1_zero = ZERO_REG && (rs1_addr == ZeroIdx);
  assign rs2_zero = ZERO_REG && (rs2_addr == ZeroIdx);
  assign rs1_hit  = wr_en && (wr_addr == rs1_addr);
  assign rs2_hit  = wr_en && (wr_addr == rs2_addr);

  always_comb begin
    rs1_data = mem_q[rs1_addr];
    if (!rs1_en || rs1_zero || in_clear) rs1_data = '0;
    else if (rs1_hit)                    rs1_data = wr_data;

    rs2_data = mem_q[rs2_addr];
    if (!rs2_en || rs2_zero || in_clear) rs2_data = '0;
    else if (rs2_hit)                    rs2_data = wr_data;
  end

  assign rs1_busy = rs1_en && pending[rs1_addr] && !rs1_hit && !rs1_zero && !in_clear;
  assign rs2_busy = rs2_en && pending[rs2_addr] && !rs2_hit && !rs2_zero && !in_clear;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised general-purpose register file for the Octa16 core. It generalises the existing 8-entry, 2-read/1-write file with configurable width and depth. It adds a hardwired-zero option, write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a sequential clear engine for context reset. It sits between the decode stage (read ports, issue) and writeback (write port).

Parameters:
DATA_WIDTH, 16, register width in bits
ADDR_WIDTH, 3, register address width; DEPTH = 2**ADDR_WIDTH entries
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes/issues; 0 = register 0 is ordinary

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  writeback write enable
wr_addr  in  ADDR_WIDTH  writeback destination
wr_data  in  DATA_WIDTH  writeback data
rs1_en  in  1  read port 1 enable
rs1_addr  in  ADDR_WIDTH  read port 1 address
rs1_data  out  DATA_WIDTH  read port 1 data (combinational)
rs1_busy  out  1  rs1_addr has an outstanding write
rs2_en  in  1  read port 2 enable
rs2_addr  in  ADDR_WIDTH  read port 2 address
rs2_data  out  DATA_WIDTH  read port 2 data (combinational)
rs2_busy  out  1  rs2_addr has an outstanding write
issue_en  in  1  decode issued an instruction that writes issue_rd
issue_rd  in  ADDR_WIDTH  destination of issued instruction
clr_req  in  1  start sequential clear, single-cycle pulse or level
clr_busy  out  1  clear engine active

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all pending bits 0, FSM in IDLE, clear counter 0, clr_busy 0. rs*_data reads 0; rs*_busy is 0.
- Write: on a rising edge, mem[wr_addr] <= wr_data when wr_en=1 and state=IDLE. It is ignored when ZERO_REG=1 and wr_addr=0.
- Read, combinational, zero latency, evaluated in priority order:
  - rsN_data = 0 if rsN_en=0, or if ZERO_REG=1 and rsN_addr=0, or if state=CLEAR.
  - Otherwise, if wr_en=1 and wr_addr=rsN_addr, rsN_data = wr_data (bypass).
  - Otherwise rsN_data = mem[rsN_addr].
- Scoreboard: one pending bit per register.
  - On a rising edge in IDLE, issue_en sets pending[issue_rd] and wr_en clears pending[wr_addr].
  - Same address, same cycle: set wins, because the newer producer is outstanding.
  - Issues and writes to register 0 are ignored when ZERO_REG=1.
- rsN_busy = rsN_en & pending[rsN_addr] & ~(wr_en & wr_addr=rsN_addr). A bypassed writeback releases the hazard in the same cycle. rsN_busy is forced 0 for the zero register and during CLEAR.
- FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1. The counter loads 0.
  - In CLEAR, each cycle does mem[cnt] <= 0 and pending[cnt] <= 0, then cnt increments.
  - CLEAR -> IDLE on the edge that clears index DEPTH-1. The clear takes exactly DEPTH cycles.
  - clr_busy = 1 exactly while state=CLEAR (Moore output).
  - In CLEAR: wr_en, issue_en and clr_req are ignored and dropped, not queued.
  - clr_req held high in IDLE after completion restarts the clear on the next cycle.
- Reset mid-clear: immediate return to IDLE with all state cleared; no partial-clear state survives.
- The counter is ADDR_WIDTH bits and wraps naturally. Completion is detected on cnt = DEPTH-1, not on overflow.

Decomposition:
- Shared package (octa16_pkg): default DATA_WIDTH/ADDR_WIDTH constants, the FSM state encoding (IDLE=0, CLEAR=1), and the zero-register index constant.
- One natural sub-module: reg_scoreboard (pending-bit array with set/clear/query logic, parametrised by ADDR_WIDTH). Storage, bypass and FSM stay in the top.

Test Plan:
- Reset/readback: release rst_n; write R3=0x1234, R5=0xBEEF on consecutive cycles; read rs1=3, rs2=5 -> 0x1234 and 0xBEEF; with rs1_en=0 -> rs1_data=0.
- Zero register: ZERO_REG=1; write R0=0xFFFF and issue R0 -> rs1_addr=0 reads 0, rs1_busy=0. With ZERO_REG=0 the same sequence -> 0xFFFF.
- Bypass: wr_en=1, wr_addr=4, wr_data=0xA5A5 while rs2_addr=4 in the same cycle -> rs2_data=0xA5A5 combinationally. The next cycle the stored value is 0xA5A5.
- Scoreboard:
  - Issue R6 -> rs1_busy=1 next cycle.
  - Writeback R6 -> rs1_busy=0 in that same cycle (bypass).
  - Same-cycle issue R2 and writeback R2 -> R2 still pending afterwards.
- Clear engine: fill all 8 registers nonzero with R1 pending; pulse clr_req -> clr_busy high for exactly 8 cycles. During that window, a wr_en to R7 is dropped and reads return 0. Afterwards all registers read 0 and no register is busy.
- Reset mid-clear: assert rst_n low at clear cycle 3 -> clr_busy=0 immediately. After release, the FSM is in IDLE, all registers are 0, and a write is accepted on the first clock.
